// File: rtl/arq_sw_tx.sv
// Stop-and-wait ARQ transmit controller: sends each frame through the FIFO/ECC stage and retries it on nack or timeout.
// Latency: capture edge t -> fifo_wr_en in t+1, fifo_rd_en in t+2, ack sampled in t+3, dst_valid in t+4 (best case).
// Backpressure: src_ready only in IDLE; with one frame in flight the downstream FIFO cannot overflow.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   src_valid/src_ready/src_data     frame input handshake (4-bit frames)
//   fifo_wr_en/fifo_rd_en/fifo_data  strobes and held frame to the FIFO stage
//   rsp_ack/rsp_nack/rsp_data        response pulses and decoded data from the ECC stage
//   dst_valid/dst_data               delivered frame (pulse / held value)
//   drop                             pulse when a frame is abandoned
//   busy                             controller is not idle
//   retry_total/drop_total           saturating retransmission and drop counters
module arq_sw_tx #(
   parameter int MAX_RETRY = 3,
   parameter int TIMEOUT   = 8,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             src_valid,
   input  logic [3:0]       src_data,
   output logic             src_ready,
   output logic             fifo_wr_en,
   output logic             fifo_rd_en,
   output logic [3:0]       fifo_data,
   input  logic             rsp_ack,
   input  logic             rsp_nack,
   input  logic [3:0]       rsp_data,
   output logic             dst_valid,
   output logic [3:0]       dst_data,
   output logic             drop,
   output logic             busy,
   output logic [CNT_W-1:0] retry_total,
   output logic [CNT_W-1:0] drop_total
);

   localparam int AW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [AW-1:0]    ATT_MAX   = AW'(MAX_RETRY);
   localparam logic [WW-1:0]    WAIT_LAST = WW'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_PUSH,
      S_POP,
      S_WAIT
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [3:0]       r_frame;
   logic [AW-1:0]    r_attempt;
   logic [WW-1:0]    r_wait;
   logic             r_wr_en;
   logic             r_rd_en;
   logic             r_dst_vld;
   logic [3:0]       r_dst_dat;
   logic             r_drop;
   logic [CNT_W-1:0] r_retry_total;
   logic [CNT_W-1:0] r_drop_total;

   logic w_capture;
   logic w_deliver;
   logic w_retry;
   logic w_drop;
   logic w_wait_inc;
   logic w_fail;

   // A nack always fails the attempt, even with a simultaneous ack.
   // Timeout only fires when nothing arrived in the last allowed cycle.
   assign w_fail = rsp_nack || (!rsp_ack && (r_wait == WAIT_LAST));

   always_comb begin
      w_next     = r_state;
      w_capture  = 1'b0;
      w_deliver  = 1'b0;
      w_retry    = 1'b0;
      w_drop     = 1'b0;
      w_wait_inc = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (src_valid) begin
               w_capture = 1'b1;
               w_next    = S_PUSH;
            end
         end
         S_PUSH: w_next = S_POP;
         S_POP:  w_next = S_WAIT;
         S_WAIT: begin
            if (w_fail) begin
               if (r_attempt < ATT_MAX) begin
                  w_retry = 1'b1;
                  w_next  = S_PUSH;
               end else begin
                  w_drop = 1'b1;
                  w_next = S_IDLE;
               end
            end else if (rsp_ack) begin
               w_deliver = 1'b1;
               w_next    = S_IDLE;
            end else begin
               w_wait_inc = 1'b1;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_frame       <= '0;
         r_attempt     <= '0;
         r_wait        <= '0;
         r_wr_en       <= 1'b0;
         r_rd_en       <= 1'b0;
         r_dst_vld     <= 1'b0;
         r_dst_dat     <= '0;
         r_drop        <= 1'b0;
         r_retry_total <= '0;
         r_drop_total  <= '0;
      end else begin
         r_state   <= w_next;
         // Strobes are registered from the next state so they line up with PUSH/POP.
         r_wr_en   <= (w_next == S_PUSH);
         r_rd_en   <= (w_next == S_POP);
         r_dst_vld <= w_deliver;
         r_drop    <= w_drop;

         if (w_capture) begin
            r_frame   <= src_data;
            r_attempt <= '0;
         end
         if (w_retry) begin
            r_attempt <= r_attempt + 1'b1;
            if (r_retry_total != CNT_MAX) r_retry_total <= r_retry_total + 1'b1;
         end
         if (w_drop && (r_drop_total != CNT_MAX)) r_drop_total <= r_drop_total + 1'b1;
         if (w_deliver) r_dst_dat <= rsp_data;

         if (r_state == S_POP)  r_wait <= '0;
         else if (w_wait_inc)   r_wait <= r_wait + 1'b1;
      end
   end

   assign src_ready   = (r_state == S_IDLE);
   assign busy        = (r_state != S_IDLE);
   // The held frame only changes on capture, which is also the edge entering PUSH.
   assign fifo_data   = r_frame;
   assign fifo_wr_en  = r_wr_en;
   assign fifo_rd_en  = r_rd_en;
   assign dst_valid   = r_dst_vld;
   assign dst_data    = r_dst_dat;
   assign drop        = r_drop;
   assign retry_total = r_retry_total;
   assign drop_total  = r_drop_total;

endmodule
